// File: rtl/fft_consts.sv
// Shared FFT constants and types: fixed-point sample format, sequencer states, default butterfly latency.
package fft_consts;

  localparam int FP_BITS     = 16;
  localparam int FRAC_BITS   = 14;
  localparam int BFU_LATENCY = 4;

  typedef struct packed {
    logic signed [FP_BITS-1:0] re;
    logic signed [FP_BITS-1:0] im;
  } complex_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } fft_ctrl_state_t;

endpackage

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register carrying {valid, addr_a, addr_b} from read issue to write-back; DEPTH cycles, no stall.
module fft_addr_delay
  import fft_consts::*;
#(
  parameter int DEPTH = 5,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr [DEPTH];

  // Clearing every tap drops in-flight writes the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per cycle, L=RD_LAT+BFU_LAT drain between stages, done pulse at end.
// No backpressure; start ignored while busy. Optional cycle counter under FFT_STAGE_CTRL_PERF_EN.
module fft_stage_ctrl
  import fft_consts::*;
#(
  parameter int  N_LOG2  = 3,
  parameter int  RD_LAT  = 1,
  parameter int  BFU_LAT = BFU_LATENCY,
  localparam int SW      = $clog2(N_LOG2 + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              bfu_en,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [SW-1:0]     stage,
  output logic [31:0]       cycle_count
);

  localparam int KW     = N_LOG2 - 1;
  localparam int HALF_N = 1 << KW;
  localparam int L      = RD_LAT + BFU_LAT;
  localparam int LW     = $clog2(L + 1);
  localparam int DW     = 1 + 2 * N_LOG2;

  fft_ctrl_state_t state;
  logic [KW-1:0]   k;
  logic [LW-1:0]   dcnt;

  // Returns {addr_a, addr_b, tw} for butterfly k of stage s.
  function automatic logic [2*N_LOG2+KW-1:0] bfly_addr(input logic [SW-1:0] s,
                                                        input logic [KW-1:0] kk);
    logic [N_LOG2-1:0] half, j, g, a;
    logic [KW-1:0]     tw;
    half = N_LOG2'(1) << s;
    j    = {1'b0, kk} & (half - N_LOG2'(1));
    g    = {1'b0, kk} >> s;
    a    = (g << (s + SW'(1))) | j;
    tw   = KW'(j << (KW - int'(s)));
    return {a, a + half, tw};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      k         <= '0;
      dcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      bfu_en    <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ISSUE;
            stage  <= '0;
            k      <= '0;
            busy   <= 1'b1;
            rd_en  <= 1'b1;
            bfu_en <= 1'b1;
            {rd_addr_a, rd_addr_b, tw_addr} <= bfly_addr('0, '0);
          end
        end
        ISSUE: begin
          if (k == KW'(HALF_N - 1)) begin
            state <= DRAIN;
            dcnt  <= '0;
            rd_en <= 1'b0;
          end else begin
            k <= k + KW'(1);
            {rd_addr_a, rd_addr_b, tw_addr} <= bfly_addr(stage, k + KW'(1));
          end
        end
        DRAIN: begin
          if (dcnt == LW'(L - 1)) begin
            if (stage == SW'(N_LOG2 - 1)) begin
              state  <= DONE;
              bfu_en <= 1'b0;
              done   <= 1'b1;
            end else begin
              state <= ISSUE;
              stage <= stage + SW'(1);
              k     <= '0;
              rd_en <= 1'b1;
              {rd_addr_a, rd_addr_b, tw_addr} <= bfly_addr(stage + SW'(1), '0);
            end
          end else begin
            dcnt <= dcnt + LW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fft_addr_delay #(
    .DEPTH (L),
    .WIDTH (DW)
  ) u_wb_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({rd_en, rd_addr_a, rd_addr_b}),
    .dout  ({wr_en, wr_addr_a, wr_addr_b})
  );

`ifdef FFT_STAGE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
    end else if (state == IDLE && start) begin
      cycle_count <= '0;
    end else if (busy) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl (N_LOG2=3, L=5): cycle model, address table, reset corners, end-to-end FFT.
module tb_fft_stage_ctrl;

  localparam int  N_LOG2 = 3;
  localparam int  N      = 1 << N_LOG2;
  localparam int  HALF   = N / 2;
  localparam int  L      = 5;
  localparam int  P      = HALF + L;
  localparam int  T_DONE = 1 + N_LOG2 * P;
  localparam real PI     = 3.14159265358979323846;
  localparam real TOL    = 1.0 / 16384.0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy, done, rd_en, bfu_en, wr_en;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [1:0]  tw_addr;
  logic [1:0]  stage;
  logic [31:0] cycle_count;

  always #5 clk = ~clk;

  fft_stage_ctrl #(.N_LOG2(N_LOG2), .RD_LAT(1), .BFU_LAT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr_a   (rd_addr_a),
    .rd_addr_b   (rd_addr_b),
    .tw_addr     (tw_addr),
    .bfu_en      (bfu_en),
    .wr_en       (wr_en),
    .wr_addr_a   (wr_addr_a),
    .wr_addr_b   (wr_addr_b),
    .stage       (stage),
    .cycle_count (cycle_count)
  );

  typedef struct {
    int a;
    int b;
    int tw;
  } trip_t;

  int  checks = 0;
  int  passed = 0;
  int  t_model = 0;
  int  exp_cnt = 0;
  bit  e2e_on = 0;
  bit  log_on = 0;
  real ram_re[N], ram_im[N];
  real qa_re[$], qa_im[$], qb_re[$], qb_im[$];
  int  qtw[$];
  int  rd_la[$], rd_lb[$], rd_lt[$], wr_la[$], wr_lb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_real(input string name, input real act, input real exp);
    real d;
    checks++;
    d = act - exp;
    if (d < 0.0) d = -d;
    if (d <= TOL) passed++;
    else $display("FAIL %s: got %f expected %f", name, act, exp);
  endtask

  // Butterflies in stage s: groups of 2*half points, k walks groups then offsets within a group.
  function automatic void pair_of(input int s, input int k, output int a, output int b, output int tw);
    int half;
    half = 1 << s;
    a    = (k / half) * 2 * half + (k % half);
    b    = a + half;
    tw   = (k % half) * (N / (2 * half));
  endfunction

  function automatic bit read_at(input int t, output int a, output int b, output int tw);
    int pos;
    a = 0; b = 0; tw = 0;
    if (t < 1 || t > T_DONE - 1) return 1'b0;
    pos = t - 1;
    if (pos % P >= HALF) return 1'b0;
    pair_of(pos / P, pos % P, a, b, tw);
    return 1'b1;
  endfunction

  task automatic compare_cycle();
    int a, b, tw, wa, wb, dummy, st;
    bit rd_e, wr_e, busy_e, done_e, bfu_e;
    logic [20:0] expv, actv;
    rd_e   = read_at(t_model, a, b, tw);
    wr_e   = read_at(t_model - L, wa, wb, dummy);
    busy_e = (t_model >= 1);
    done_e = (t_model == T_DONE);
    bfu_e  = (t_model >= 1 && t_model < T_DONE);
    st     = busy_e ? ((t_model - 1) / P > N_LOG2 - 1 ? N_LOG2 - 1 : (t_model - 1) / P) : 0;
    expv = {busy_e, done_e, rd_e, bfu_e, wr_e,
            3'(a), 3'(b), 2'(tw), 3'(wa), 3'(wb), 2'(st)};
    actv = {busy, done, rd_en, bfu_en, wr_en,
            rd_e ? rd_addr_a : 3'd0, rd_e ? rd_addr_b : 3'd0, rd_e ? tw_addr : 2'd0,
            wr_e ? wr_addr_a : 3'd0, wr_e ? wr_addr_b : 3'd0, busy_e ? stage : 2'd0};
    check($sformatf("cycle t=%0d", t_model), 64'(actv), 64'(expv));
`ifdef FFT_STAGE_CTRL_PERF_EN
    check($sformatf("cycle_count t=%0d", t_model), 64'(cycle_count), 64'(exp_cnt));
`else
    check($sformatf("cycle_count t=%0d", t_model), 64'(cycle_count), 64'd0);
`endif
  endtask

  task automatic e2e_step();
    real ar, ai, br, bi, wre, wim, tr, ti, ang;
    int  tw;
    if (wr_en) begin
      if (qtw.size() == 0) begin
        checks++;
        $display("FAIL e2e_queue: write with no pending read, got empty expected nonempty");
      end else begin
        ar  = qa_re.pop_front();
        ai  = qa_im.pop_front();
        br  = qb_re.pop_front();
        bi  = qb_im.pop_front();
        tw  = qtw.pop_front();
        ang = 2.0 * PI * real'(tw) / real'(N);
        wre = $cos(ang);
        wim = -$sin(ang);
        tr  = br * wre - bi * wim;
        ti  = br * wim + bi * wre;
        ram_re[wr_addr_a] = ar + tr;
        ram_im[wr_addr_a] = ai + ti;
        ram_re[wr_addr_b] = ar - tr;
        ram_im[wr_addr_b] = ai - ti;
      end
    end
    if (rd_en) begin
      qa_re.push_back(ram_re[rd_addr_a]);
      qa_im.push_back(ram_im[rd_addr_a]);
      qb_re.push_back(ram_re[rd_addr_b]);
      qb_im.push_back(ram_im[rd_addr_b]);
      qtw.push_back(int'(tw_addr));
    end
  endtask

  // One clock: drive start, advance the model at the edge, check at the falling edge.
  task automatic cycle(input logic st);
    int t_old;
    t_old = t_model;
    start = st;
    @(posedge clk);
    if (t_old == 0) begin
      if (st) begin
        t_model = 1;
        exp_cnt = 0;
      end
    end else begin
      exp_cnt++;
      t_model = (t_old == T_DONE) ? 0 : t_old + 1;
    end
    @(negedge clk);
    compare_cycle();
    if (e2e_on) e2e_step();
    if (log_on) begin
      if (rd_en) begin
        rd_la.push_back(int'(rd_addr_a));
        rd_lb.push_back(int'(rd_addr_b));
        rd_lt.push_back(int'(tw_addr));
      end
      if (wr_en) begin
        wr_la.push_back(int'(wr_addr_a));
        wr_lb.push_back(int'(wr_addr_b));
      end
    end
  endtask

  task automatic async_reset_pulse(input string name);
    rst_n = 1'b0;
    #1;
    check({name, "_wr_en"}, 64'(wr_en), 64'd0);
    check({name, "_busy_rd"}, 64'({busy, rd_en, bfu_en, done}), 64'd0);
    t_model = 0;
    exp_cnt = 0;
    #1 rst_n = 1'b1;
  endtask

  task automatic run_e2e(input string name);
    qa_re.delete(); qa_im.delete(); qb_re.delete(); qb_im.delete(); qtw.delete();
    e2e_on = 1;
    cycle(1'b1);
    for (int i = 0; i < T_DONE + 2; i++) cycle(1'b0);
    e2e_on = 0;
    for (int i = 0; i < N; i++) begin
      check_real($sformatf("%s_re[%0d]", name, i), ram_re[i], (name == "dc" && i != 0) ? 0.0 : 1.0);
      check_real($sformatf("%s_im[%0d]", name, i), ram_im[i], 0.0);
    end
  endtask

  trip_t tbl[12];

  initial begin
    tbl = '{'{0, 1, 0}, '{2, 3, 0}, '{4, 5, 0}, '{6, 7, 0},
            '{0, 2, 0}, '{1, 3, 2}, '{4, 6, 0}, '{5, 7, 2},
            '{0, 4, 0}, '{1, 5, 1}, '{2, 6, 2}, '{3, 7, 3}};

    // Reset held with start high: everything quiet.
    start = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", 64'({busy, done, rd_en, bfu_en, wr_en, rd_addr_a, rd_addr_b,
                                  tw_addr, wr_addr_a, wr_addr_b, stage}), 64'd0);
      check("reset_cycle_count", 64'(cycle_count), 64'd0);
    end
    rst_n = 1'b1;

    // First transform with start pulses at t=5 and in DONE, reads/writes logged.
    log_on = 1;
    cycle(1'b1);
    check("accept_after_reset", 64'(rd_en), 64'd1);
    for (int i = 0; i < T_DONE; i++) cycle(t_model == 5 || t_model == T_DONE);
    cycle(1'b0);
    log_on = 0;
`ifdef FFT_STAGE_CTRL_PERF_EN
    check("cycle_count_final", 64'(cycle_count), 64'd28);
`else
    check("cycle_count_final", 64'(cycle_count), 64'd0);
`endif
    check("read_count", 64'(rd_la.size()), 64'd12);
    check("write_count", 64'(wr_la.size()), 64'd12);
    for (int i = 0; i < 12; i++) begin
      if (i < rd_la.size()) begin
        check($sformatf("tbl_rd[%0d]", i), 64'({8'(rd_la[i]), 8'(rd_lb[i]), 8'(rd_lt[i])}),
              64'({8'(tbl[i].a), 8'(tbl[i].b), 8'(tbl[i].tw)}));
      end
      if (i < wr_la.size()) begin
        check($sformatf("tbl_wr[%0d]", i), 64'({8'(wr_la[i]), 8'(wr_lb[i])}),
              64'({8'(tbl[i].a), 8'(tbl[i].b)}));
      end
    end

    // Reset mid-transform: once with writes in flight, once at t=12.
    foreach (tbl[i]) begin
      if (i < 2) begin
        cycle(1'b1);
        while (t_model < (i == 0 ? 7 : 12)) cycle(1'b0);
        async_reset_pulse($sformatf("rst_mid_t%0d", t_model));
        cycle(1'b0);
      end
    end

    // start held: restart on the cycle after DONE returns to IDLE.
    for (int i = 0; i < 2 * (T_DONE + 1) + 1; i++) cycle(1'b1);
    for (int i = 0; i < T_DONE + 2; i++) cycle(1'b0);

    // End-to-end: impulse and DC through a behavioural RAM + butterfly.
    for (int i = 0; i < N; i++) begin
      ram_re[i] = (i == 0) ? 1.0 : 0.0;
      ram_im[i] = 0.0;
    end
    run_e2e("impulse");
    for (int i = 0; i < N; i++) begin
      ram_re[i] = 0.125;
      ram_im[i] = 0.0;
    end
    run_e2e("dc");

    // Random start traffic with occasional asynchronous resets.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 149) == 0) async_reset_pulse("rst_rand");
      else cycle($urandom_range(0, 3) == 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
